vlan_tag_inserter: RTL and testbench



---
 rtl/vlan_tag_inserter.sv | 250 +++++++++++++++++++++++++
 tb/tb_vlan_tag_inserter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlan_tag_inserter.sv
// ---------------------------------------------------------------------------
// vlan_tag_inserter
//
// Transmit-side 802.1Q tag inserter. Accepts an untagged Ethernet frame as an
// 8-bit valid/ready byte stream and, when tagging is requested with frame
// byte 0, inserts a 4-byte tag (TPID + TCI) after the 12 MAC address bytes.
// Frames that are not tagged pass through unchanged. The output is a single
// register stage: an accepted input byte appears on m_data one cycle later.
//
// Optional build macro: QINQ_EN
//   When defined, adds qinq_en / svlan_id inputs. A frame with insert_en and
//   qinq_en set receives an outer S-tag (88 A8, {4'b0, svlan_id}) ahead of
//   the C-tag, i.e. 8 inserted bytes. Without the macro the tag is 4 bytes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    input byte handshake
//   s_data, s_last     input byte, end-of-frame marker
//   m_valid/m_ready    output byte handshake (m_* registered)
//   m_data, m_last     output byte, end-of-frame marker
//   insert_en          tag this frame (sampled with byte 0)
//   vlan_pcp/dei/id    TCI fields (sampled with byte 0)
//   qinq_en, svlan_id  S-tag request and S-VID (QINQ_EN builds only)
//   runt_err           one-cycle pulse: frame ended before byte index 13
//   tagged_cnt         number of frames that received a tag (wraps)
// ---------------------------------------------------------------------------
module vlan_tag_inserter #(
    parameter logic [15:0] TPID  = 16'h8100,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             insert_en,
    input  logic [2:0]       vlan_pcp,
    input  logic             vlan_dei,
    input  logic [11:0]      vlan_id,
`ifdef QINQ_EN
    input  logic             qinq_en,
    input  logic [11:0]      svlan_id,
`endif
    output logic             runt_err,
    output logic [CNT_W-1:0] tagged_cnt
);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_TAG  = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

`ifdef QINQ_EN
    localparam int TIDX_W = 3;
`else
    localparam int TIDX_W = 2;
`endif

    localparam logic [3:0] IDX_LAST_MAC = 4'd11;
    localparam logic [3:0] IDX_SAT      = 4'd13;

    // Registered state
    logic [1:0]        state_q,      state_d;
    logic [3:0]        byte_cnt_q,   byte_cnt_d;
    logic [TIDX_W-1:0] tag_idx_q,    tag_idx_d;
    logic              ins_q,        ins_d;
    logic [15:0]       tci_q,        tci_d;
`ifdef QINQ_EN
    logic              qinq_q,       qinq_d;
    logic [11:0]       svid_q,       svid_d;
`endif
    logic              m_valid_q,    m_valid_d;
    logic [7:0]        m_data_q,     m_data_d;
    logic              m_last_q,     m_last_d;
    logic              runt_err_q,   runt_err_d;
    logic [CNT_W-1:0]  tagged_cnt_q, tagged_cnt_d;

    // Combinational helpers
    logic              load_ok;
    logic              s_acc;
    logic              tag_last;
    logic [2:0]        tag_sel;
    logic [7:0]        tag_byte;

    // The output register may take a new byte when it is empty or its
    // current byte is being consumed this cycle.
    assign load_ok = !m_valid_q || m_ready;
    assign s_ready = load_ok && (state_q != ST_TAG);
    assign s_acc   = s_valid && s_ready;

    // Tag byte selection. The 8-entry table is laid out as the full Q-in-Q
    // sequence; a plain C-tag uses only its upper half (entries 4..7).
    always_comb begin
`ifdef QINQ_EN
        tag_sel  = qinq_q ? tag_idx_q : (tag_idx_q + 3'd4);
        tag_last = qinq_q ? (tag_idx_q == 3'd7) : (tag_idx_q == 3'd3);
`else
        tag_sel  = {1'b1, tag_idx_q};
        tag_last = (tag_idx_q == 2'd3);
`endif
        tag_byte = 8'h00;
        case (tag_sel)
`ifdef QINQ_EN
            3'd0:    tag_byte = 8'h88;
            3'd1:    tag_byte = 8'hA8;
            3'd2:    tag_byte = {4'b0000, svid_q[11:8]};
            3'd3:    tag_byte = svid_q[7:0];
`endif
            3'd4:    tag_byte = TPID[15:8];
            3'd5:    tag_byte = TPID[7:0];
            3'd6:    tag_byte = tci_q[15:8];
            3'd7:    tag_byte = tci_q[7:0];
            default: tag_byte = 8'h00;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tag_idx_d    = tag_idx_q;
        ins_d        = ins_q;
        tci_d        = tci_q;
`ifdef QINQ_EN
        qinq_d       = qinq_q;
        svid_d       = svid_q;
`endif
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        runt_err_d   = 1'b0;
        tagged_cnt_d = tagged_cnt_q;

        // Per-frame tag parameters are captured only with byte 0 so that
        // later changes on these inputs cannot affect the frame in flight.
        if (s_acc && (byte_cnt_q == 4'd0)) begin
            ins_d = insert_en;
            tci_d = {vlan_pcp, vlan_dei, vlan_id};
`ifdef QINQ_EN
            qinq_d = qinq_en;
            svid_d = svlan_id;
`endif
        end

        // Byte position within the frame; saturates once past the point
        // where position still matters (tag decision and runt detection).
        if (s_acc) begin
            if (s_last) begin
                byte_cnt_d = 4'd0;
            end else if (byte_cnt_q != IDX_SAT) begin
                byte_cnt_d = byte_cnt_q + 4'd1;
            end
        end

        if (s_acc && s_last && (byte_cnt_q < IDX_SAT)) begin
            runt_err_d = 1'b1;
        end

        // Output register load: tag bytes take priority while in TAG (the
        // input is stalled then), otherwise forward the accepted byte.
        if (load_ok) begin
            if (state_q == ST_TAG) begin
                m_valid_d = 1'b1;
                m_data_d  = tag_byte;
                m_last_d  = 1'b0;
            end else if (s_acc) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                m_last_d  = s_last;
            end else begin
                m_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_HDR: begin
                // Byte 11 is the last source-MAC byte; the tag follows it
                // only if the frame continues beyond it.
                if (s_acc && !s_last && (byte_cnt_q == IDX_LAST_MAC) && ins_q) begin
                    state_d      = ST_TAG;
                    tag_idx_d    = '0;
                    tagged_cnt_d = tagged_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_TAG: begin
                if (load_ok) begin
                    if (tag_last) begin
                        state_d   = ST_BODY;
                        tag_idx_d = '0;
                    end else begin
                        tag_idx_d = tag_idx_q + {{(TIDX_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_BODY: begin
                if (s_acc && s_last) begin
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            byte_cnt_q   <= 4'd0;
            tag_idx_q    <= '0;
            ins_q        <= 1'b0;
            tci_q        <= 16'h0000;
`ifdef QINQ_EN
            qinq_q       <= 1'b0;
            svid_q       <= 12'h000;
`endif
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'h00;
            m_last_q     <= 1'b0;
            runt_err_q   <= 1'b0;
            tagged_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tag_idx_q    <= tag_idx_d;
            ins_q        <= ins_d;
            tci_q        <= tci_d;
`ifdef QINQ_EN
            qinq_q       <= qinq_d;
            svid_q       <= svid_d;
`endif
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            runt_err_q   <= runt_err_d;
            tagged_cnt_q <= tagged_cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign runt_err   = runt_err_q;
    assign tagged_cnt = tagged_cnt_q;

endmodule

// File: tb/tb_vlan_tag_inserter.sv
// ---------------------------------------------------------------------------
// tb_vlan_tag_inserter
//
// Self-checking bench for vlan_tag_inserter. Frames of random bytes are
// driven through the valid/ready input; a monitor collects every accepted
// output byte. The reference model builds the expected byte stream directly
// from the frame contents: frames of 13+ bytes with insert_en get
// 81 00 TCIhi TCIlo spliced in before byte 12, all others pass unchanged.
// ---------------------------------------------------------------------------
module tb_vlan_tag_inserter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        insert_en = 1'b0;
    logic [2:0]  vlan_pcp = 3'd0;
    logic        vlan_dei = 1'b0;
    logic [11:0] vlan_id = 12'h000;
`ifdef QINQ_EN
    logic        qinq_en = 1'b0;
    logic [11:0] svlan_id = 12'h000;
`endif
    logic        runt_err;
    logic [15:0] tagged_cnt;

    always #5 clk = ~clk;

    vlan_tag_inserter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .insert_en  (insert_en),
        .vlan_pcp   (vlan_pcp),
        .vlan_dei   (vlan_dei),
        .vlan_id    (vlan_id),
`ifdef QINQ_EN
        .qinq_en    (qinq_en),
        .svlan_id   (svlan_id),
`endif
        .runt_err   (runt_err),
        .tagged_cnt (tagged_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Observation state
    logic [7:0] out_data[$];
    logic       out_last[$];
    int         runt_seen = 0;
    int         stall_cycles = 0;
    int         hold_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    bit         rnd_ready = 1'b0;

    // Reference model state
    logic [7:0] frm[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];
    int         exp_runt = 0;
    int         exp_tagged = 0;

    always @(negedge clk) begin
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                hold_viol++;
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (runt_err === 1'b1) runt_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic make_frame(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    endtask

    // Expected output for the frame in frm, appended to the expected stream.
    task automatic model_frame(input logic ins, input logic [2:0] pcp,
                               input logic dei, input logic [11:0] vid);
        int         len;
        logic [15:0] tci;
        len = frm.size();
        tci = {pcp, dei, vid};
        for (int i = 0; i < len; i++) begin
            if (ins && len >= 13 && i == 12) begin
                exp_data.push_back(8'h81); exp_last.push_back(1'b0);
                exp_data.push_back(8'h00); exp_last.push_back(1'b0);
                exp_data.push_back(tci[15:8]); exp_last.push_back(1'b0);
                exp_data.push_back(tci[7:0]); exp_last.push_back(1'b0);
            end
            exp_data.push_back(frm[i]);
            exp_last.push_back(i == len - 1);
        end
        if (len <= 13) exp_runt++;
        if (ins && len >= 13) exp_tagged++;
    endtask

    // Drive the first n_send bytes of frm. Tag inputs are randomised on
    // every byte except byte 0 to show they are ignored mid-frame.
    task automatic drive_frame(input int n_send, input bit idle_after, input logic ins,
                               input logic [2:0] pcp, input logic dei, input logic [11:0] vid);
        int i = 0;
        int guard = 0;
        while (i < n_send) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = frm[i];
            s_last  = (i == frm.size() - 1);
            if (i == 0) begin
                insert_en = ins; vlan_pcp = pcp; vlan_dei = dei; vlan_id = vid;
            end else begin
                insert_en = 1'($urandom); vlan_pcp = 3'($urandom);
                vlan_dei = 1'($urandom); vlan_id = 12'($urandom);
            end
            #1;
            if (s_ready) i++;
            else stall_cycles++;
            guard++;
            if (guard > 4000) begin
                vectors++; miscompares++;
                $display("FAIL drive_timeout: accepted %0d bytes, want %0d", i, n_send);
                break;
            end
        end
        if (idle_after) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (out_data.size() < n && g < 4000) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_obs();
        out_data.delete(); out_last.delete();
        exp_data.delete(); exp_last.delete();
        runt_seen = 0; stall_cycles = 0; hold_viol = 0; exp_runt = 0;
    endtask

    function automatic int stream_errs();
        int e = 0;
        if (out_data.size() != exp_data.size()) e++;
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            if (out_data[i] !== exp_data[i]) e++;
            if (out_last[i] !== exp_last[i]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b d=%h l=%b, want 0 00 0", m_valid, m_data, m_last);
        end
        vectors++;
        if (runt_err !== 1'b0 || tagged_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stat: got runt=%b cnt=%0d, want 0 0", runt_err, tagged_cnt);
        end
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, want 1", s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tagged();
        logic [7:0] tag_ref [4] = '{8'h81, 8'h00, 8'hA1, 8'h23};
        int e;
        clear_obs();
        rnd_ready = 1'b0;
        make_frame(64);
        model_frame(1'b1, 3'd5, 1'b0, 12'h123);
        drive_frame(64, 1'b1, 1'b1, 3'd5, 1'b0, 12'h123);
        wait_out(68);
        e = stream_errs();
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL tagged_stream: got %0d errors over %0d bytes, want 0 over %0d",
                     e, out_data.size(), exp_data.size());
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_data.size() < 16 || out_data[12+k] !== tag_ref[k]) begin
                miscompares++;
                $display("FAIL tagged_tag%0d: got %h, want %h", k,
                         (out_data.size() > 12 + k) ? out_data[12+k] : 8'hxx, tag_ref[k]);
            end
        end
        vectors++;
        if (stall_cycles !== 4) begin
            miscompares++;
            $display("FAIL tagged_stall: got %0d cycles, want 4", stall_cycles);
        end
        vectors++;
        if (tagged_cnt !== 16'(exp_tagged) || runt_seen !== 0) begin
            miscompares++;
            $display("FAIL tagged_cnt: got cnt=%0d runt=%0d, want %0d 0", tagged_cnt, runt_seen, exp_tagged);
        end
    endtask

    task automatic test_passthru();
        int e;
        clear_obs();
        model_frame(1'b0, 3'd5, 1'b0, 12'h123);
        drive_frame(64, 1'b1, 1'b0, 3'd5, 1'b0, 12'h123);
        wait_out(64);
        e = stream_errs();
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL passthru_stream: got %0d errors over %0d bytes, want 0 over 64", e, out_data.size());
        end
        vectors++;
        if (tagged_cnt !== 16'(exp_tagged) || runt_seen !== 0) begin
            miscompares++;
            $display("FAIL passthru_stat: got cnt=%0d runt=%0d, want %0d 0", tagged_cnt, runt_seen, exp_tagged);
        end
    endtask

    // Short frames: 10 bytes, ending exactly at index 11, and at index 12.
    task automatic test_runt();
        int lens [3] = '{10, 12, 13};
        int e;
        for (int t = 0; t < 3; t++) begin
            clear_obs();
            make_frame(lens[t]);
            model_frame(1'b1, 3'd2, 1'b1, 12'h5A5);
            drive_frame(lens[t], 1'b1, 1'b1, 3'd2, 1'b1, 12'h5A5);
            wait_out(exp_data.size());
            e = stream_errs();
            vectors++;
            if (e !== 0) begin
                miscompares++;
                $display("FAIL runt_stream len=%0d: got %0d errors, %0d bytes, want 0, %0d",
                         lens[t], e, out_data.size(), exp_data.size());
            end
            vectors++;
            if (runt_seen !== 1 || tagged_cnt !== 16'(exp_tagged)) begin
                miscompares++;
                $display("FAIL runt_stat len=%0d: got runt=%0d cnt=%0d, want 1 %0d",
                         lens[t], runt_seen, tagged_cnt, exp_tagged);
            end
        end
    endtask

    task automatic test_backpressure();
        int e;
        clear_obs();
        rnd_ready = 1'b1;
        make_frame(64);
        model_frame(1'b1, 3'd5, 1'b0, 12'h123);
        drive_frame(64, 1'b1, 1'b1, 3'd5, 1'b0, 12'h123);
        wait_out(68);
        rnd_ready = 1'b0;
        repeat (2) @(negedge clk);
        e = stream_errs();
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL bp_stream: got %0d errors over %0d bytes, want 0 over 68", e, out_data.size());
        end
        vectors++;
        if (hold_viol !== 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d changes while stalled, want 0", hold_viol);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int base;
        clear_obs();
        make_frame(60);
        model_frame(1'b1, 3'd5, 1'b0, 12'h001);
        drive_frame(60, 1'b0, 1'b1, 3'd5, 1'b0, 12'h001);
        make_frame(60);
        model_frame(1'b1, 3'd5, 1'b0, 12'hFFF);
        drive_frame(60, 1'b1, 1'b1, 3'd5, 1'b0, 12'hFFF);
        wait_out(128);
        e = stream_errs();
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL b2b_stream: got %0d errors over %0d bytes, want 0 over 128", e, out_data.size());
        end
        base = 64;
        vectors++;
        if (out_data.size() < 80 || out_data[base+14] !== 8'hAF || out_data[base+15] !== 8'hFF) begin
            miscompares++;
            $display("FAIL b2b_tci2: got %h%h, want AFFF",
                     (out_data.size() > 78) ? out_data[base+14] : 8'hxx,
                     (out_data.size() > 79) ? out_data[base+15] : 8'hxx);
        end
        vectors++;
        if (stall_cycles !== 8 || tagged_cnt !== 16'(exp_tagged)) begin
            miscompares++;
            $display("FAIL b2b_stat: got stalls=%0d cnt=%0d, want 8 %0d", stall_cycles, tagged_cnt, exp_tagged);
        end
    endtask

    task automatic test_reset_mid_tag();
        int g = 0;
        int e;
        clear_obs();
        make_frame(64);
        drive_frame(12, 1'b1, 1'b1, 3'd5, 1'b0, 12'h123);
        // 14 bytes out (12 header + 81 00) means the third tag byte is loading.
        while (out_data.size() < 14 && g < 100) begin
            @(negedge clk);
            g++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || tagged_cnt !== 16'd0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_tag: got v=%b cnt=%0d rdy=%b, want 0 0 1", m_valid, tagged_cnt, s_ready);
        end
        exp_tagged = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_obs();
        make_frame(64);
        model_frame(1'b1, 3'd5, 1'b0, 12'h123);
        drive_frame(64, 1'b1, 1'b1, 3'd5, 1'b0, 12'h123);
        wait_out(68);
        e = stream_errs();
        vectors++;
        if (e !== 0 || tagged_cnt !== 16'(exp_tagged)) begin
            miscompares++;
            $display("FAIL rst_recover: got %0d errors cnt=%0d, want 0 %0d", e, tagged_cnt, exp_tagged);
        end
    endtask

    task automatic test_random();
        int e;
        int len;
        logic       ins;
        logic [2:0] pcp;
        logic       dei;
        logic [11:0] vid;
        clear_obs();
        rnd_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 69);
            if (len == 14) len = 15;
            ins = 1'($urandom); pcp = 3'($urandom); dei = 1'($urandom); vid = 12'($urandom);
            make_frame(len);
            model_frame(ins, pcp, dei, vid);
            drive_frame(len, 1'($urandom), ins, pcp, dei, vid);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_out(exp_data.size());
        rnd_ready = 1'b0;
        repeat (2) @(negedge clk);
        e = stream_errs();
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL rand_stream: got %0d errors over %0d bytes, want 0 over %0d",
                     e, out_data.size(), exp_data.size());
        end
        vectors++;
        if (runt_seen !== exp_runt || tagged_cnt !== 16'(exp_tagged) || hold_viol !== 0) begin
            miscompares++;
            $display("FAIL rand_stat: got runt=%0d cnt=%0d hold=%0d, want %0d %0d 0",
                     runt_seen, tagged_cnt, hold_viol, exp_runt, exp_tagged);
        end
    endtask

    initial begin
        test_reset();
        test_tagged();
        test_passthru();
        test_runt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tag();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
